nand_sweep_tester: RTL and testbench

//  Self-checking exhaustive stimulus/checker for an N-input NAND gate under test.

---
 rtl/nand_sweep_pkg.sv | 23 ++
 rtl/nand_sweep_tester_if.sv | 26 ++
 rtl/nand_pattern_gen.sv | 71 +++++++
 rtl/nand_sweep_tester.sv | 109 ++++++++++
 tb/tb_nand_sweep_tester.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/nand_sweep_pkg.sv
// Shared types and helpers for the NAND gate sweep tester.
// Pattern ordering and the reference NAND result live here so both RTL files agree.
package nand_sweep_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int MAX_N = 16;

  function automatic logic [MAX_N:0] bin2gray(input logic [MAX_N:0] idx);
    return idx ^ (idx >> 1);
  endfunction

  // Bits at or above n are forced high so they cannot affect the reduction.
  function automatic logic nand_exp(input logic [MAX_N-1:0] vec, input int n);
    logic [MAX_N-1:0] v;
    v = vec;
    for (int i = 0; i < MAX_N; i++) begin
      if (i >= n) v[i] = 1'b1;
    end
    return ~&v;
  endfunction

endpackage

// File: rtl/nand_sweep_tester_if.sv
// Bundle between the sweep tester and the gate under test / lab harness.
// The master side is the tester; the slave side drives start and returns dut_y.
interface nand_sweep_if #(
  parameter int N    = 4,
  parameter int ERRW = 8
);
  logic            start;
  logic            dut_y;
  logic [N-1:0]    stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic [ERRW-1:0] err_cnt;
  logic            fail_valid;
  logic [N-1:0]    fail_vec;

  modport master (
    input  start, dut_y,
    output stim, busy, done, pass, err_cnt, fail_valid, fail_vec
  );

  modport slave (
    output start, dut_y,
    input  stim, busy, done, pass, err_cnt, fail_valid, fail_vec
  );
endinterface

// File: rtl/nand_pattern_gen.sv
// Pattern sequencer: holds each index for HOLD clocks and maps it to binary or Gray stimulus.
// sample_stb marks the last hold cycle of a pattern; last marks the final index.
module nand_pattern_gen
  import nand_sweep_pkg::*;
#(
  parameter int N    = 4,
  parameter int HOLD = 50,
  parameter int GRAY = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         run,
  output logic [N-1:0] stim,
  output logic         sample_stb,
  output logic         last
);

  localparam int HW = $clog2(HOLD);

  // One extra index bit keeps the count from wrapping at N=16.
  logic [N:0]    idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  stim_q, stim_d;

  function automatic logic [N-1:0] map_idx(input logic [N:0] idx);
    logic [MAX_N:0] wide;
    wide = (MAX_N+1)'(idx);
    if (GRAY != 0) wide = bin2gray(wide);
    return wide[N-1:0];
  endfunction

  assign sample_stb = run && (hold_q == HW'(HOLD - 1));
  assign last       = (idx_q == (N+1)'((1 << N) - 1));
  assign stim       = stim_q;

  always_comb begin
    idx_d  = idx_q;
    hold_d = hold_q;
    stim_d = stim_q;
    if (load) begin
      idx_d  = '0;
      hold_d = '0;
      stim_d = map_idx('0);
    end else if (sample_stb) begin
      hold_d = '0;
      if (last) begin
        idx_d  = '0;
        stim_d = '0;
      end else begin
        idx_d  = idx_q + (N+1)'(1);
        stim_d = map_idx(idx_q + (N+1)'(1));
      end
    end else if (run) begin
      hold_d = hold_q + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      hold_q <= '0;
      stim_q <= '0;
    end else begin
      idx_q  <= idx_d;
      hold_q <= hold_d;
      stim_q <= stim_d;
    end
  end

endmodule

// File: rtl/nand_sweep_tester.sv
// Exhaustive sweep checker for an N-input NAND gate: drives every pattern, compares dut_y
// against the ideal NAND, counts mismatches (saturating) and captures the first failing vector.
module nand_sweep_tester
  import nand_sweep_pkg::*;
#(
  parameter int N    = 4,
  parameter int HOLD = 50,
  parameter int GRAY = 0,
  parameter int ERRW = 8
) (
  input logic         clk,
  input logic         rst_n,
  nand_sweep_if.master bus
);

  state_e          state_q, state_d;
  logic            pass_q, pass_d;
  logic [ERRW-1:0] err_q, err_d;
  logic            fv_q, fv_d;
  logic [N-1:0]    fvec_q, fvec_d;

  logic         load;
  logic         run;
  logic [N-1:0] stim;
  logic         sample_stb;
  logic         last;
  logic         mismatch;

  assign run = (state_q == RUN);

  nand_pattern_gen #(
    .N    (N),
    .HOLD (HOLD),
    .GRAY (GRAY)
  ) u_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .run        (run),
    .stim       (stim),
    .sample_stb (sample_stb),
    .last       (last)
  );

  assign mismatch = (bus.dut_y != nand_exp(MAX_N'(stim), N));

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    load    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          load    = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = '0;
        end
      end
      RUN: begin
        if (sample_stb) begin
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + ERRW'(1);
            if (!fv_q) begin
              fv_d   = 1'b1;
              fvec_d = stim;
            end
          end
          // pass uses the post-compare count so a final-pattern miss is included.
          if (last) begin
            state_d = DONE;
            pass_d  = (err_d == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
    end
  end

  assign bus.stim       = stim;
  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_q;
  assign bus.fail_valid = fv_q;
  assign bus.fail_vec   = fvec_q;

endmodule

// File: tb/tb_nand_sweep_tester.sv
// Bench for nand_sweep_tester: three instances (binary, Gray, 3-bit counter) share one
// faulty-gate model whose per-pattern fault mask is set before each sweep.
module tb_nand_sweep_tester;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mask;

  always #5 clk = ~clk;

  nand_sweep_if #(.N(4), .ERRW(8)) b0 ();
  nand_sweep_if #(.N(4), .ERRW(8)) b1 ();
  nand_sweep_if #(.N(4), .ERRW(3)) b2 ();

  nand_sweep_tester #(.N(4), .HOLD(2), .GRAY(0), .ERRW(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  nand_sweep_tester #(.N(4), .HOLD(2), .GRAY(1), .ERRW(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  nand_sweep_tester #(.N(4), .HOLD(2), .GRAY(0), .ERRW(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  // Gate under test: ideal NAND, inverted on every pattern whose mask bit is set.
  assign b0.dut_y = ~(&b0.stim) ^ mask[b0.stim];
  assign b1.dut_y = ~(&b1.stim) ^ mask[b1.stim];
  assign b2.dut_y = ~(&b2.stim) ^ mask[b2.stim];

  typedef struct packed {
    logic [3:0] stim;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err;
    logic       fv;
    logic [3:0] fvec;
  } obs_t;

  obs_t obs [3];

  always_comb begin
    obs[0] = '{b0.stim, b0.busy, b0.done, b0.pass, b0.err_cnt, b0.fail_valid, b0.fail_vec};
    obs[1] = '{b1.stim, b1.busy, b1.done, b1.pass, b1.err_cnt, b1.fail_valid, b1.fail_vec};
    obs[2] = '{b2.stim, b2.busy, b2.done, b2.pass, 8'(b2.err_cnt), b2.fail_valid, b2.fail_vec};
  end

  typedef struct packed {
    logic [15:0]      mask;
    int               mid;
    logic [2:0][7:0]  e_err;
    logic [2:0]       e_fv;
    logic [2:0][3:0]  e_fvec;
    logic [2:0]       e_pass;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[inst %0d]: got %0h expected %0h", name, k, act, exp);
  endtask

  task automatic set_start(input logic v);
    b0.start = v;
    b1.start = v;
    b2.start = v;
  endtask

  function automatic logic [3:0] order(input int k, input int i);
    int g;
    g = (k == 1) ? (i ^ (i >> 1)) : i;
    return 4'(g);
  endfunction

  // Reference: walk the sweep order, count faulty patterns, remember the first one.
  function automatic vec_t model(input logic [15:0] m, input int mid);
    vec_t v;
    int   cnt;
    int   sat;
    bit   got;
    logic [3:0] s;
    logic [3:0] first;
    v      = '0;
    v.mask = m;
    v.mid  = mid;
    for (int k = 0; k < 3; k++) begin
      sat   = (k == 2) ? 7 : 255;
      cnt   = 0;
      got   = 0;
      first = '0;
      for (int i = 0; i < 16; i++) begin
        s = order(k, i);
        if (m[s]) begin
          cnt++;
          if (!got) begin
            got   = 1;
            first = s;
          end
        end
      end
      v.e_err[k]  = 8'((cnt > sat) ? sat : cnt);
      v.e_fv[k]   = got;
      v.e_fvec[k] = first;
      v.e_pass[k] = (cnt == 0);
    end
    return v;
  endfunction

  task automatic run_sweep(input vec_t v);
    int         seq_bad [3];
    int         ham_bad;
    logic [3:0] prev;
    mask = v.mask;
    for (int k = 0; k < 3; k++) seq_bad[k] = 0;
    ham_bad = 0;
    prev    = '0;
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    for (int c = 0; c < 32; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) begin
        for (int k = 0; k < 3; k++) begin
          chk("clear_done", k, 32'(obs[k].done), 32'd0);
          chk("clear_err", k, 32'(obs[k].err), 32'd0);
          chk("clear_fail_valid", k, 32'(obs[k].fv), 32'd0);
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (obs[k].stim !== order(k, c / 2) || obs[k].busy !== 1'b1) seq_bad[k]++;
      end
      if (c > 0 && (c % 2) == 0 && $countones(obs[1].stim ^ prev) != 1) ham_bad++;
      prev = obs[1].stim;
      if (v.mid >= 0 && c == v.mid) set_start(1'b1);
      if (v.mid >= 0 && c == v.mid + 1) set_start(1'b0);
    end
    set_start(1'b0);
    @(negedge clk);
    chk("gray_hamming", 1, 32'(ham_bad), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("seq_bad_cycles", k, 32'(seq_bad[k]), 32'd0);
      chk("end_busy", k, 32'(obs[k].busy), 32'd0);
      chk("end_done", k, 32'(obs[k].done), 32'd1);
      chk("end_stim", k, 32'(obs[k].stim), 32'd0);
      chk("pass", k, 32'(obs[k].pass), 32'(v.e_pass[k]));
      chk("err_cnt", k, 32'(obs[k].err), 32'(v.e_err[k]));
      chk("fail_valid", k, 32'(obs[k].fv), 32'(v.e_fv[k]));
      chk("fail_vec", k, 32'(obs[k].fvec), 32'(v.e_fvec[k]));
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  vec_t tab [9];

  initial begin
    int n;
    rst_n = 1'b0;
    mask  = '0;
    set_start(1'b0);

    tab[0] = '{16'h0000, -1, {8'd0, 8'd0, 8'd0}, 3'b000, {4'h0, 4'h0, 4'h0}, 3'b111};
    tab[1] = '{16'h8000, 8, {8'd1, 8'd1, 8'd1}, 3'b111, {4'hF, 4'hF, 4'hF}, 3'b000};
    tab[2] = '{16'h7FFF, -1, {8'd7, 8'd15, 8'd15}, 3'b111, {4'h0, 4'h0, 4'h0}, 3'b000};
    tab[3] = '{16'h0090, 3, {8'd2, 8'd2, 8'd2}, 3'b111, {4'h4, 4'h7, 4'h4}, 3'b000};
    tab[4] = '{16'h0000, 20, {8'd0, 8'd0, 8'd0}, 3'b000, {4'h0, 4'h0, 4'h0}, 3'b111};
    for (int r = 5; r < 9; r++) begin
      tab[r] = model(16'($urandom) & 16'($urandom),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 29)) : -1);
    end

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk("reset_outputs", k, 32'(obs[k]), 32'd0);
    rst_n = 1'b1;

    for (int t = 0; t < 9; t++) run_sweep(tab[t]);

    // Async abort mid-sweep with errors already counted.
    mask = 16'h7FFF;
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    n = 0;
    while (obs[0].stim != 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx5", 0, 32'(obs[0].stim), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("abort_outputs", k, 32'(obs[k]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(tab[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
